// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong game sequencer.
//   state_t      - sequencer FSM state encoding (also exported for debug)
//   COL_LEFT/RIGHT - ball columns where paddle hit/miss is decided
//   WIN_*        - encodings of the winner output
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] COL_LEFT  = 4'd1;
  localparam logic [3:0] COL_RIGHT = 4'd14;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/tick_timer.sv
// tick_timer: 10-bit game-tick counter shared by the timed states.
//   clk, reset_n : system clock, async active-low reset
//   clr          : synchronous clear (wins over tick)
//   tick         : game-rate strobe, counted when high
//   limit        : tick count that ends the current interval
//   done         : high on the tick that brings the count up to limit
//   blink        : selected bit of the next count, used for display blinking
module tick_timer #(
  parameter int BLINK_BIT = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       tick,
  input  logic [9:0] limit,
  output logic       done,
  output logic       blink
);

  logic [9:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (tick) count_d = count_q + 10'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // Looks only at the registered count so the FSM can use done to decide
  // whether to clear this counter without forming a combinational loop.
  assign done  = tick & ((count_q + 10'd1) == limit);
  assign blink = count_d[BLINK_BIT];

endmodule

// File: rtl/pong_ctrl.sv
// pong_ctrl: match sequencer for pong (serve delay, hit/miss, scoring,
// point pause, game over).
//   clk, reset_n        : system clock, async active-low reset
//   tick                : 1 kHz game strobe
//   start               : player start button (level, synchronised)
//   ball_x/y/dx         : current ball position and horizontal direction
//   lpaddle/rpaddle     : paddle row occupancy
//   ball_run            : ball may advance on ticks
//   ball_serve          : one-clk pulse, reload ball at centre toward serve_dir
//   serve_dir           : next serve direction, 1 = right
//   bounce_x            : one-clk pulse, reverse ball horizontally
//   score_l/score_r     : player scores
//   winner              : WIN_NONE / WIN_LEFT / WIN_RIGHT
//   blank               : display ball/paddles off (point blink)
//   state               : FSM state for debug
//
// state | meaning
// IDLE  | power-up, waiting for a start edge
// SERVE | ball held at centre for SERVE_TICKS ticks
// PLAY  | ball moving, hit/miss evaluated on each tick
// POINT | pause with blinking for POINT_TICKS ticks after a score
// OVER  | match finished, winner shown, waiting for a start edge
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_TICKS = 500,
  parameter int POINT_TICKS = 1000,
  parameter int WIN_SCORE   = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        start,
  input  logic [3:0]  ball_x,
  input  logic [3:0]  ball_y,
  input  logic        ball_dx,
  input  logic [15:0] lpaddle,
  input  logic [15:0] rpaddle,
  output logic        ball_run,
  output logic        ball_serve,
  output logic        serve_dir,
  output logic        bounce_x,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  winner,
  output logic        blank,
  output logic [2:0]  state
);

  localparam logic [3:0] WIN       = 4'(WIN_SCORE);
  localparam logic [9:0] SERVE_LIM = 10'(SERVE_TICKS);
  localparam logic [9:0] POINT_LIM = 10'(POINT_TICKS);

  state_t     state_q, state_d;
  logic       start_q;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       ball_serve_q, ball_serve_d;
  logic       bounce_q, bounce_d;
  logic       ball_run_q, ball_run_d;
  logic       blank_q, blank_d;
  logic       start_edge, tmr_clr, tmr_done, tmr_blink;
  logic [9:0] tmr_limit;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == WIN) ? s : s + 4'd1;
  endfunction

  assign start_edge = start & ~start_q;
  assign tmr_limit  = (state_q == ST_POINT) ? POINT_LIM : SERVE_LIM;
  // Clearing on any state change also swallows a tick that coincides
  // with a start edge.
  assign tmr_clr    = (state_d != state_q);

  tick_timer #(.BLINK_BIT(6)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .tick    (tick),
    .limit   (tmr_limit),
    .done    (tmr_done),
    .blink   (tmr_blink)
  );

  always_comb begin
    state_d      = state_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    ball_serve_d = 1'b0;
    bounce_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d      = ST_SERVE;
          ball_serve_d = 1'b1;
          serve_dir_d  = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tmr_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          if (ball_x == COL_LEFT && !ball_dx) begin
            if (lpaddle[ball_y]) begin
              bounce_d = 1'b1;
            end else begin
              score_r_d   = sat_inc(score_r_q);
              serve_dir_d = 1'b0;
              state_d     = ST_POINT;
            end
          end else if (ball_x == COL_RIGHT && ball_dx) begin
            if (rpaddle[ball_y]) begin
              bounce_d = 1'b1;
            end else begin
              score_l_d   = sat_inc(score_l_q);
              serve_dir_d = 1'b1;
              state_d     = ST_POINT;
            end
          end
        end
      end
      ST_POINT: begin
        if (tmr_done) begin
          if (score_l_q == WIN || score_r_q == WIN) begin
            state_d  = ST_OVER;
            winner_d = (score_l_q == WIN) ? WIN_LEFT : WIN_RIGHT;
          end else begin
            state_d      = ST_SERVE;
            ball_serve_d = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d      = ST_SERVE;
          score_l_d    = '0;
          score_r_d    = '0;
          winner_d     = WIN_NONE;
          serve_dir_d  = 1'b1;
          ball_serve_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Kept outside the FSM block: blink depends on the timer clear, which
  // itself depends on state_d.
  assign ball_run_d = (state_d == ST_PLAY);
  assign blank_d    = (state_d == ST_POINT) & tmr_blink;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= WIN_NONE;
      serve_dir_q  <= 1'b1;
      ball_serve_q <= 1'b0;
      bounce_q     <= 1'b0;
      ball_run_q   <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      ball_serve_q <= ball_serve_d;
      bounce_q     <= bounce_d;
      ball_run_q   <= ball_run_d;
      blank_q      <= blank_d;
    end
  end

  assign ball_run   = ball_run_q;
  assign ball_serve = ball_serve_q;
  assign serve_dir  = serve_dir_q;
  assign bounce_x   = bounce_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign winner     = winner_q;
  assign blank      = blank_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Bench for pong_ctrl: a rule-level match model checked against the DUT on
// every negedge, plus directed scenarios with literal expectations.
module tb_pong_ctrl;

  localparam int SERVE_T = 500;
  localparam int POINT_T = 1000;
  localparam int WIN     = 9;

  logic        clk, reset_n, tick, start, ball_dx;
  logic [3:0]  ball_x, ball_y;
  logic [15:0] lpaddle, rpaddle;
  logic        ball_run, ball_serve, serve_dir, bounce_x, blank;
  logic [3:0]  score_l, score_r;
  logic [1:0]  winner;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 0;

  pong_ctrl #(.SERVE_TICKS(SERVE_T), .POINT_TICKS(POINT_T), .WIN_SCORE(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .ball_dx(ball_dx),
    .lpaddle(lpaddle), .rpaddle(rpaddle),
    .ball_run(ball_run), .ball_serve(ball_serve), .serve_dir(serve_dir),
    .bounce_x(bounce_x), .score_l(score_l), .score_r(score_r),
    .winner(winner), .blank(blank), .state(state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Match model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over.
  typedef struct packed {
    int phase; int ticks; int sl; int sr; int win;
    bit dir; bit serve; bit bounce; bit run; bit blank; bit sprev;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.dir = 1;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit tk, bit st, int x, int y,
                                        bit dx, logic [15:0] lp, logic [15:0] rp);
    model_t n;
    bit pressed;
    n = c;
    n.serve = 0;
    n.bounce = 0;
    pressed = st && !c.sprev;
    n.sprev = st;
    case (c.phase)
      0: if (pressed) begin n.phase = 1; n.serve = 1; n.dir = 1; n.ticks = 0; end
      1: if (tk) begin
           n.ticks = c.ticks + 1;
           if (n.ticks == SERVE_T) begin n.phase = 2; n.ticks = 0; end
         end
      2: if (tk) begin
           if (x == 1 && !dx) begin
             if (lp[y]) n.bounce = 1;
             else begin
               n.sr = (c.sr < WIN) ? c.sr + 1 : c.sr;
               n.dir = 0; n.phase = 3; n.ticks = 0;
             end
           end else if (x == 14 && dx) begin
             if (rp[y]) n.bounce = 1;
             else begin
               n.sl = (c.sl < WIN) ? c.sl + 1 : c.sl;
               n.dir = 1; n.phase = 3; n.ticks = 0;
             end
           end
         end
      3: if (tk) begin
           n.ticks = c.ticks + 1;
           if (n.ticks == POINT_T) begin
             n.ticks = 0;
             if (c.sl == WIN || c.sr == WIN) begin
               n.phase = 4;
               n.win = (c.sl == WIN) ? 1 : 2;
             end else begin
               n.phase = 1; n.serve = 1;
             end
           end
         end
      4: if (pressed) begin
           n.phase = 1; n.sl = 0; n.sr = 0; n.win = 0;
           n.dir = 1; n.serve = 1; n.ticks = 0;
         end
      default: n = model_reset();
    endcase
    n.run = (n.phase == 2);
    n.blank = (n.phase == 3) && ((n.ticks / 64) % 2 == 1);
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else m <= model_step(m, tick, start, int'(ball_x), int'(ball_y), ball_dx, lpaddle, rpaddle);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (state !== 3'(m.phase) || score_l !== 4'(m.sl) || score_r !== 4'(m.sr) ||
          winner !== 2'(m.win) || serve_dir !== m.dir || ball_serve !== m.serve ||
          bounce_x !== m.bounce || ball_run !== m.run || blank !== m.blank) begin
        miscompares++;
        $display("FAIL model t=%0t got st=%0d sl=%0d sr=%0d win=%0d dir=%0b srv=%0b bnc=%0b run=%0b blk=%0b expected st=%0d sl=%0d sr=%0d win=%0d dir=%0b srv=%0b bnc=%0b run=%0b blk=%0b",
                 $time, state, score_l, score_r, winner, serve_dir, ball_serve, bounce_x, ball_run, blank,
                 m.phase, m.sl, m.sr, m.win, m.dir, m.serve, m.bounce, m.run, m.blank);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    @(posedge clk); #1 tick = 1;
    @(posedge clk); #1 tick = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; tick = 0; start = 0; ball_dx = 0;
    ball_x = 4'd7; ball_y = 4'd0; lpaddle = '0; rpaddle = '0;
    cyc(3);
    cmp_en = 1;
    chk("reset_state", state, 0);
    chk("reset_scores", {score_l, score_r}, 0);
    chk("reset_winner", winner, 0);
    chk("reset_serve_dir", serve_dir, 1);
    chk("reset_pulses", {ball_run, ball_serve, bounce_x, blank}, 0);

    @(posedge clk); #1 reset_n = 1;
    cyc(2);
    start = 1;
    cyc(1);
    chk("start_serve_pulse", ball_serve, 1);
    chk("start_state", state, 1);
    cyc(1);
    chk("serve_pulse_one_clk", ball_serve, 0);
    ticks(SERVE_T - 1);
    chk("serve_499", state, 1);
    do_tick();
    chk("serve_500_play", state, 2);
    chk("play_run", ball_run, 1);

    // left hit
    ball_x = 4'd1; ball_dx = 0; ball_y = 4'd5; lpaddle = 16'h0070;
    do_tick();
    chk("left_hit_bounce", bounce_x, 1);
    chk("left_hit_scores", {score_l, score_r}, 0);
    ball_dx = 1;
    cyc(1);
    chk("left_hit_pulse_one_clk", bounce_x, 0);

    // right hit
    ball_x = 4'd14; ball_dx = 1; ball_y = 4'd9; rpaddle = 16'h0200;
    do_tick();
    chk("right_hit_bounce", bounce_x, 1);

    // no false trigger: non-edge columns and wrong directions, empty paddles
    lpaddle = '0; rpaddle = '0;
    for (int i = 0; i < 20; i++) begin
      case (i % 6)
        0: begin ball_x = 4'd1;  ball_dx = 1; end
        1: begin ball_x = 4'd14; ball_dx = 0; end
        2: begin ball_x = 4'd0;  ball_dx = 0; end
        3: begin ball_x = 4'd15; ball_dx = 1; end
        4: begin ball_x = 4'd2;  ball_dx = 0; end
        default: begin ball_x = 4'd13; ball_dx = 1; end
      endcase
      ball_y = 4'(i);
      do_tick();
    end
    chk("no_false_state", state, 2);
    chk("no_false_scores", {score_l, score_r}, 0);

    // left miss
    ball_x = 4'd1; ball_dx = 0; ball_y = 4'd5; lpaddle = 16'h0007;
    do_tick();
    chk("left_miss_score_r", score_r, 1);
    chk("left_miss_serve_dir", serve_dir, 0);
    chk("left_miss_state", state, 3);
    chk("left_miss_run", ball_run, 0);
    ball_x = 4'd7;
    ticks(63);
    chk("blink_63", blank, 0);
    do_tick();
    chk("blink_64", blank, 1);
    ticks(64);
    chk("blink_128", blank, 0);
    ticks(POINT_T - 128 - 1);
    chk("point_999", state, 3);
    do_tick();
    chk("point_1000_state", state, 1);
    chk("point_1000_serve", ball_serve, 1);
    ticks(SERVE_T);
    chk("reserve_play", state, 2);

    // left player wins 9 points on right misses
    ball_x = 4'd14; ball_dx = 1; rpaddle = '0;
    for (int p = 1; p <= WIN; p++) begin
      do_tick();
      chk("left_point_score", score_l, 32'(p));
      ticks(POINT_T);
      if (p < WIN) ticks(SERVE_T);
    end
    chk("over_state", state, 4);
    chk("over_winner", winner, 1);
    chk("over_score_l", score_l, 9);
    chk("over_blank", blank, 0);
    cyc(5);
    chk("over_held_start", state, 4);

    // fresh start edge coinciding with a tick
    start = 0;
    cyc(1);
    start = 1; tick = 1;
    cyc(1);
    tick = 0;
    chk("restart_state", state, 1);
    chk("restart_serve", ball_serve, 1);
    chk("restart_scores", {score_l, score_r}, 0);
    chk("restart_winner", winner, 0);
    chk("restart_dir", serve_dir, 1);
    ticks(SERVE_T - 1);
    chk("restart_serve_499", state, 1);
    do_tick();
    chk("restart_play", state, 2);

    // reset in the middle of POINT
    ball_x = 4'd1; ball_dx = 0; lpaddle = '0;
    do_tick();
    chk("pre_reset_point", state, 3);
    ball_x = 4'd7;
    ticks(100);
    @(posedge clk); #2 reset_n = 0; start = 0;
    #1;
    chk("async_reset_state", state, 0);
    chk("async_reset_scores", {score_l, score_r}, 0);
    chk("async_reset_dir", serve_dir, 1);
    cyc(2);
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("post_reset_no_serve", {state, ball_serve}, 0);
    end

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
